// File: rtl/dac_sample_streamer.sv
// dac_sample_streamer
// Output stage between the plb_dac register logic and the 10-bit parallel DAC.
// Samples are buffered in a FIFO and paced out at a programmable rate, with a
// DCLKIO strobe that rises at least one clock after the data settles. The FSM
// also sequences DAC power-down and wake-up.
//
// Optional build macro: DAC_TEST_RAMP_EN adds a test_ramp input. While it is
// high in RUN, each sample slot increments S_Data instead of popping the FIFO.
//
// S_Data carries the sample value numerically (bit DATA_W-1 is the sample MSB).
// The board netlist maps that bit to DAC pin index 0.
//
// state | meaning
// ------+---------------------------------------------------------------
// OFF   | DAC powered down, S_Data at midscale, waiting for enable
// WAKE  | PWRDN released, counting WAKE_CYC clocks of settling time
// RUN   | samples popped every P clocks, DCLKIO toggling

module dac_sample_streamer #(
    parameter int DATA_W     = 10,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16,
    parameter int WAKE_CYC   = 64
) (
    input  logic                          Bus2IP_Clk,
    input  logic                          Bus2IP_Reset,
    input  logic                          enable,
    input  logic                          pwrdn_req,
    input  logic                          fmt_twos,
    input  logic [DIV_W-1:0]              rate_div,
`ifdef DAC_TEST_RAMP_EN
    input  logic                          test_ramp,
`endif
    input  logic                          wr_valid,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic                          clr_underflow,
    output logic                          underflow,
    output logic [DATA_W-1:0]             S_Data,
    output logic                          S_DCLKIO,
    output logic                          S_PWRDN,
    output logic                          S_Format,
    output logic                          S_PinMD,
    output logic                          S_ClkMD
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int CW  = DIV_W + 1;
    localparam int WCW = $clog2(WAKE_CYC + 1);

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_WAKE = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [1:0]        state, state_next;
    logic [WCW-1:0]    wake_cnt;
    logic [CW-1:0]     cnt, per_r, per_new, per_cur;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     level;

    logic full, empty, run_exit, flush, wr_fire;
    logic go_wake, run_stay, slot, ramp_on, pop, uf_set;

    function automatic logic [DATA_W-1:0] mid_code(input logic f);
        mid_code = f ? '0 : {1'b1, {(DATA_W-1){1'b0}}};
    endfunction

`ifdef DAC_TEST_RAMP_EN
    assign ramp_on = test_ramp;
`else
    assign ramp_on = 1'b0;
`endif

    assign full     = (level == LW'(FIFO_DEPTH));
    assign empty    = (level == '0);
    assign go_wake  = (state == ST_OFF) && enable && !pwrdn_req;
    assign run_exit = (state == ST_RUN) && (!enable || pwrdn_req);
    assign run_stay = (state == ST_RUN) && !run_exit;
    assign flush    = run_exit;
    assign wr_ready = !full && !flush;
    assign wr_fire  = wr_valid && wr_ready;

    // rate_div of 0 behaves as 1, so the shortest period is two clocks
    assign per_new  = (rate_div == '0) ? CW'(2) : CW'(rate_div) + CW'(1);
    assign per_cur  = (cnt == '0) ? per_new : per_r;
    assign slot     = run_stay && (cnt == '0);
    assign pop      = slot && !empty && !ramp_on;
    assign uf_set   = slot && empty && !ramp_on;

    assign fifo_level = level;
    assign S_PinMD    = 1'b0;
    assign S_ClkMD    = 1'b0;

    // Next-state decode for the power sequencing FSM
    always_comb begin
        state_next = state;
        case (state)
            ST_OFF:  if (go_wake) state_next = ST_WAKE;
            ST_WAKE: begin
                if (!enable || pwrdn_req) state_next = ST_OFF;
                else if (wake_cnt == '0)  state_next = ST_RUN;
            end
            ST_RUN:  if (run_exit) state_next = ST_OFF;
            default: state_next = ST_OFF;
        endcase
    end

    // State register and wake settling down-counter
    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            state    <= ST_OFF;
            wake_cnt <= '0;
        end else begin
            state <= state_next;
            if (go_wake)
                wake_cnt <= WCW'(WAKE_CYC - 1);
            else if (state == ST_WAKE && wake_cnt != '0)
                wake_cnt <= wake_cnt - WCW'(1);
        end
    end

    // Sample-period counter; the period is re-sampled at the start of each slot
    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            cnt   <= '0;
            per_r <= CW'(2);
        end else if (run_stay) begin
            if (cnt == '0)
                per_r <= per_new;
            cnt <= (cnt == per_cur - CW'(1)) ? '0 : cnt + CW'(1);
        end else begin
            cnt <= '0;
        end
    end

    // DAC pin registers; DCLKIO lags cnt by one clock so data leads the rising edge
    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            S_Data   <= mid_code(1'b0);
            S_DCLKIO <= 1'b0;
            S_PWRDN  <= 1'b1;
            S_Format <= 1'b0;
        end else begin
            S_PWRDN  <= (state_next == ST_OFF);
            S_DCLKIO <= run_stay && (cnt >= (per_cur >> 1));
            if (go_wake) begin
                S_Format <= fmt_twos;
                S_Data   <= mid_code(fmt_twos);
            end else if (state_next == ST_OFF) begin
                S_Data   <= mid_code(S_Format);
            end else if (pop) begin
                S_Data   <= mem[rd_ptr];
            end else if (slot && ramp_on) begin
                S_Data   <= S_Data + DATA_W'(1);
            end
        end
    end

    // Sticky underflow flag; a new underflow wins over a simultaneous clear
    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset)
            underflow <= 1'b0;
        else if (uf_set)
            underflow <= 1'b1;
        else if (clr_underflow)
            underflow <= 1'b0;
    end

    // FIFO pointers and occupancy; leaving RUN discards all queued samples
    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(wr_fire) - LW'(pop);
        end
    end

    // FIFO storage array, no reset needed since occupancy gates every read
    always_ff @(posedge Bus2IP_Clk) begin
        if (wr_fire)
            mem[wr_ptr] <= wr_data;
    end

endmodule
